inv_key_schedule: RTL and testbench

Reverse AES-128 key expansion engine for on-the-fly decryption. It is loaded with any round key (typically the round-10 key) and steps backward one round per request, presenting round keys r, r-1, ..., 0 to the inverse cipher datapath. This is the inverse of the forward round-key generator, which derives key r from key r-1. It uses a single shared 8-bit S-box, so SubWord is evaluated serially over 4 cycles.

---
 rtl/inv_key_schedule.sv | 242 ++++++++++++++++++++++++
 tb/tb_inv_key_schedule.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_key_schedule.sv
// Reverse AES-128 key expansion: steps round key r back to r-1 on request.
// FULL_SBOX_EN: four parallel S-boxes, single-cycle step instead of serial SUB.
module inv_key_schedule #(
  parameter int SBOX_LAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [127:0] key_in,
  input  logic [3:0]   round_in,
  input  logic         next,
  output logic [127:0] roundkey,
  output logic [3:0]   round,
  output logic         valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    READY,
    SUB,
    UPDATE
  } state_t;

  localparam logic [3:0] LAT = 4'(SBOX_LAT);

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    c = 8'h00;
    unique case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [3:0]   wt_q, wt_d;
`ifndef FULL_SBOX_EN
  logic [1:0]   cnt_q, cnt_d;
  logic [31:0]  tmp_q, tmp_d;
  logic [7:0]   sb_in;
  logic [7:0]   sb_out;
`endif

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] rot;
  logic [31:0] sub_word;
  logic        load_ok;
  logic        accept;

  assign w0  = key_q[127:96];
  assign w1  = key_q[95:64];
  assign w2  = key_q[63:32];
  assign w3  = key_q[31:0];
  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = {p3[23:0], p3[31:24]};

`ifdef FULL_SBOX_EN
  assign sub_word = {sbox(rot[31:24]), sbox(rot[23:16]),
                     sbox(rot[15:8]),  sbox(rot[7:0])};
`else
  // Shared S-box fed with byte cnt of RotWord(p3), MSB first
  always_comb begin
    sb_in = rot[31:24];
    unique case (cnt_q)
      2'd0: sb_in = rot[31:24];
      2'd1: sb_in = rot[23:16];
      2'd2: sb_in = rot[15:8];
      2'd3: sb_in = rot[7:0];
      default: sb_in = rot[31:24];
    endcase
  end
  assign sb_out   = sbox(sb_in);
  assign sub_word = tmp_q;
`endif

  assign p0 = w0 ^ sub_word ^ {rcon(round_q), 24'h0};

  assign load_ok = load && (round_in <= 4'd10);
  assign accept  = next && (state_q == READY) && (round_q != 4'd0);

  // Next-state: load override, step acceptance, serial sub, commit
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    wt_d    = wt_q;
`ifndef FULL_SBOX_EN
    cnt_d   = cnt_q;
    tmp_d   = tmp_q;
`endif
    if (load_ok) begin
      key_d   = key_in;
      round_d = round_in;
      valid_d = 1'b1;
      busy_d  = 1'b0;
      wt_d    = '0;
      state_d = READY;
`ifndef FULL_SBOX_EN
      cnt_d   = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: ;
        READY: begin
          if (accept) begin
            valid_d = 1'b0;
            busy_d  = 1'b1;
            wt_d    = '0;
`ifdef FULL_SBOX_EN
            state_d = UPDATE;
`else
            cnt_d   = '0;
            state_d = SUB;
`endif
          end
        end
        SUB: begin
`ifndef FULL_SBOX_EN
          if (wt_q != LAT) begin
            wt_d = wt_q + 4'd1;
          end else begin
            wt_d  = '0;
            tmp_d = {tmp_q[23:0], sb_out};
            if (cnt_q == 2'd3) state_d = UPDATE;
            else cnt_d = cnt_q + 2'd1;
          end
`else
          state_d = IDLE;
`endif
        end
        UPDATE: begin
`ifdef FULL_SBOX_EN
          if (wt_q != LAT) begin
            wt_d = wt_q + 4'd1;
          end else begin
`else
          begin
`endif
            key_d   = {p0, p1, p2, p3};
            round_d = round_q - 4'd1;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = READY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    done_d = valid_d && (round_d == 4'd0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wt_q    <= '0;
`ifndef FULL_SBOX_EN
      cnt_q   <= '0;
      tmp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wt_q    <= wt_d;
`ifndef FULL_SBOX_EN
      cnt_q   <= cnt_d;
      tmp_q   <= tmp_d;
`endif
    end
  end

  assign roundkey = key_q;
  assign round    = round_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: known AES-128 round keys and step timing.
// Expected keys queued at each step request, popped when valid returns.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   round_in = '0;
  logic         next = 1'b0;
  logic [127:0] roundkey;
  logic [3:0]   round;
  logic         valid;
  logic         busy;
  logic         done;

  inv_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .load(load), .key_in(key_in),
    .round_in(round_in), .next(next), .roundkey(roundkey),
    .round(round), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

`ifdef FULL_SBOX_EN
  localparam int STEP_LAT = 1;
`else
  localparam int STEP_LAT = 5;
`endif

  localparam logic [127:0] K3 = 128'hD2600DE7_157ABC68_6339E901_C3031EFB;
  localparam logic [127:0] K2 = 128'h56082007_C71AB18F_76435569_A03AF7FA;
  localparam logic [127:0] K1 = 128'hE232FCF1_91129188_B159E4E6_D679A293;
  localparam logic [127:0] K0 = 128'h54686174_73206D79_204B756E_67204675;
  localparam logic [127:0] K9 = 128'hBFE2BF90_4559FAB2_A16480B4_F7F1CBD8;
  localparam logic [127:0] K8 = 128'h8E51EF21_FABB4522_E43D7A06_56954B6C;

  typedef struct packed {
    logic [127:0] k;
    logic [3:0]   r;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_load(input logic [127:0] k, input logic [3:0] r);
    @(posedge clk); #1;
    load = 1'b1; key_in = k; round_in = r;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic pulse_next(output int t0);
    @(posedge clk); #1;
    next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_valid(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        lat = cyc - t0;
        return;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({roundkey, round, valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %h/%0d v%b b%b d%b want zeros",
               roundkey, round, valid, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({roundkey, round, valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_release: got %h/%0d v%b b%b d%b want zeros",
               roundkey, round, valid, busy, done);
    end
  endtask

  task automatic test_chain;
    logic [127:0] ek [3];
    int t0, lat;
    exp_t e;
    ek[0] = K2; ek[1] = K1; ek[2] = K0;
    do_load(K3, 4'd3);
    @(negedge clk);
    checks++;
    if (roundkey !== K3 || round !== 4'd3 || valid !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL chain_load: got %h/%0d v%b b%b d%b want %h/3 v1 b0 d0",
               roundkey, round, valid, busy, done, K3);
    end
    for (int i = 0; i < 3; i++) begin
      q.push_back('{k: ek[i], r: 4'(2 - i)});
      pulse_next(t0);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || valid !== 1'b0) begin
        errors++;
        $display("FAIL chain_busy%0d: got b%b v%b want b1 v0", i, busy, valid);
      end
      wait_valid(t0, lat);
      checks++;
      if (lat != STEP_LAT) begin
        errors++;
        $display("FAIL chain_lat%0d: got %0d want %0d", i, lat, STEP_LAT);
      end
      e = q.pop_front();
      checks++;
      if (roundkey !== e.k || round !== e.r || busy !== 1'b0 ||
          done !== (e.r == 4'd0)) begin
        errors++;
        $display("FAIL chain_key%0d: got %h/%0d b%b d%b want %h/%0d",
                 i, roundkey, round, busy, done, e.k, e.r);
      end
    end
  endtask

  task automatic test_boundary;
    int t0, lat;
    exp_t e;
    pulse_next(t0);
    repeat (7) @(negedge clk);
    checks++;
    if (roundkey !== K0 || round !== 4'd0 || valid !== 1'b1 ||
        done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL round0_next: got %h/%0d v%b d%b b%b want %h/0 v1 d1 b0",
               roundkey, round, valid, done, busy, K0);
    end
    do_load(K3, 4'd3);
    q.push_back('{k: K2, r: 4'd2});
    pulse_next(t0);
    next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    wait_valid(t0, lat);
    checks++;
    if (lat != STEP_LAT) begin
      errors++;
      $display("FAIL stray_next_lat: got %0d want %0d", lat, STEP_LAT);
    end
    e = q.pop_front();
    checks++;
    if (roundkey !== e.k || round !== e.r) begin
      errors++;
      $display("FAIL stray_next_key: got %h/%0d want %h/%0d",
               roundkey, round, e.k, e.r);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (round !== 4'd2 || valid !== 1'b1 || roundkey !== K2) begin
      errors++;
      $display("FAIL stray_next_queued: got %h/%0d v%b want %h/2 v1",
               roundkey, round, valid, K2);
    end
  endtask

  task automatic test_rcon;
    int t0, lat;
    exp_t e;
    do_load(K9, 4'd9);
    q.push_back('{k: K8, r: 4'd8});
    pulse_next(t0);
    wait_valid(t0, lat);
    checks++;
    if (lat != STEP_LAT) begin
      errors++;
      $display("FAIL rcon_lat: got %0d want %0d", lat, STEP_LAT);
    end
    e = q.pop_front();
    checks++;
    if (roundkey !== e.k || round !== e.r || done !== 1'b0) begin
      errors++;
      $display("FAIL rcon_key: got %h/%0d d%b want %h/%0d d0",
               roundkey, round, done, e.k, e.r);
    end
  endtask

  task automatic test_load_wins;
    int t0;
    @(posedge clk); #1;
    load = 1'b1; next = 1'b1; key_in = K9; round_in = 4'd9;
    @(posedge clk); #1;
    load = 1'b0; next = 1'b0;
    @(negedge clk);
    checks++;
    if (roundkey !== K9 || round !== 4'd9 || valid !== 1'b1 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL load_next_same: got %h/%0d v%b b%b want %h/9 v1 b0",
               roundkey, round, valid, busy, K9);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (round !== 4'd9 || roundkey !== K9 || valid !== 1'b1) begin
      errors++;
      $display("FAIL load_next_nostep: got %h/%0d v%b want %h/9 v1",
               roundkey, round, valid, K9);
    end
    pulse_next(t0);
    load = 1'b1; key_in = K3; round_in = 4'd3;
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    checks++;
    if (roundkey !== K3 || round !== 4'd3 || valid !== 1'b1 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL load_abort: got %h/%0d v%b b%b want %h/3 v1 b0",
               roundkey, round, valid, busy, K3);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (round !== 4'd3 || roundkey !== K3 || valid !== 1'b1) begin
      errors++;
      $display("FAIL load_abort_hold: got %h/%0d v%b want %h/3 v1",
               roundkey, round, valid, K3);
    end
  endtask

  task automatic test_invalid_load;
    do_load(K0, 4'd11);
    @(negedge clk);
    checks++;
    if (roundkey !== K3 || round !== 4'd3 || valid !== 1'b1 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL invalid_load: got %h/%0d v%b b%b want %h/3 v1 b0",
               roundkey, round, valid, busy, K3);
    end
  endtask

  task automatic test_reset_mid;
    int t0;
    pulse_next(t0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({roundkey, round, valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h/%0d v%b b%b d%b want zeros",
               roundkey, round, valid, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_next(t0);
    repeat (6) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || round !== 4'd0 ||
        roundkey !== '0) begin
      errors++;
      $display("FAIL idle_next: got %h/%0d v%b b%b want zeros",
               roundkey, round, valid, busy);
    end
  endtask

  initial begin
    test_reset;
    test_chain;
    test_boundary;
    test_rcon;
    test_load_wins;
    test_invalid_load;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
